// File: rtl/sram_pkg.sv
// Shared types and default geometry for the SRAM host controller.
// Contents: controller state enum and default address/data/depth sizes.
// Imported by sram_ctrl and sram_bus_drv.
package sram_pkg;

  localparam int SRAM_ADDR_W = 4;
  localparam int SRAM_DATA_W = 32;
  localparam int SRAM_DEPTH  = 16;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_DATA,
    TURN,
    INIT
  } sram_ctrl_state_t;

endpackage

// File: rtl/sram_bus_drv.sv
// Tri-state driver for the bidirectional SRAM data bus.
// Ports: drive_en enables dout onto pad; din always mirrors pad.
// Purely combinational, no state.
module sram_bus_drv
  import sram_pkg::*;
#(
  parameter int W = SRAM_DATA_W
) (
  input  logic         drive_en,
  input  logic [W-1:0] dout,
  output logic [W-1:0] din,
  inout  wire  [W-1:0] pad
);

  assign pad = drive_en ? dout : 'z;
  assign din = pad;

endmodule

// File: rtl/sram_ctrl.sv
// Host-side controller for a single-port SRAM: turns a valid/ready request
// stream into write / read cycles, returns read data on a one-cycle strobe,
// and runs a hardware fill of the whole array with one pattern.
// Ports: clk, rst_n (sync, active-low); req_* host request; init_* fill
// control; rsp_* read response; sram_* SRAM pins (sram_data bidirectional).
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W,
  parameter int DEPTH  = SRAM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              init_start,
  input  logic [DATA_W-1:0] init_data,
  output logic              init_busy,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              sram_cs,
  output logic              sram_we,
  output logic              sram_oe,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data
);

  sram_ctrl_state_t state, next_state;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              drive_q;
  logic [DATA_W-1:0] sram_din;

  logic accept;
  logic init_go;
  logic cnt_last;

  // Next-cycle values of the registered strobes.
  logic cs_d, we_d, oe_d, busy_d, rsp_d;

  // init_start wins over a simultaneous request, so ready drops with it.
  assign req_ready = rst_n && (state == IDLE) && !init_start;
  assign accept    = (state == IDLE) && req_valid && !init_start;
  assign init_go   = (state == IDLE) && init_start;
  assign cnt_last  = (cnt_q == ADDR_W'(DEPTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (init_start) begin
          next_state = INIT;
        end else if (req_valid) begin
          next_state = req_we ? WR : RD_ADDR;
        end
      end
      WR:      next_state = IDLE;
      RD_ADDR: next_state = RD_DATA;
      RD_DATA: next_state = TURN;
      // Bus released for one cycle so a following write cannot collide
      // with the SRAM still turning its drivers off.
      TURN:    next_state = IDLE;
      INIT:    next_state = cnt_last ? IDLE : INIT;
      default: next_state = IDLE;
    endcase
  end

  // Output decode, computed from next_state so every strobe can be
  // registered and still appear in the cycle the state is entered.
  always_comb begin
    cs_d   = 1'b0;
    we_d   = 1'b0;
    oe_d   = 1'b0;
    busy_d = 1'b0;
    rsp_d  = 1'b0;
    case (next_state)
      WR: begin
        cs_d = 1'b1;
        we_d = 1'b1;
      end
      RD_ADDR, RD_DATA: begin
        cs_d = 1'b1;
        oe_d = 1'b1;
      end
      TURN: rsp_d = 1'b1;
      INIT: begin
        cs_d   = 1'b1;
        we_d   = 1'b1;
        busy_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Output registers, request latch and fill counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sram_cs   <= 1'b0;
      sram_we   <= 1'b0;
      sram_oe   <= 1'b0;
      drive_q   <= 1'b0;
      init_busy <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      sram_cs   <= cs_d;
      sram_we   <= we_d;
      sram_oe   <= oe_d;
      // Bus drive tracks write enable only, so it can never overlap oe.
      drive_q   <= we_d;
      init_busy <= busy_d;
      rsp_valid <= rsp_d;

      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end else if (init_go) begin
        addr_q  <= '0;
        cnt_q   <= '0;
        wdata_q <= init_data;
      end else if (state == INIT) begin
        // DEPTH is 2**ADDR_W, so the increment wraps to 0 after the last word.
        cnt_q  <= cnt_q + 1'b1;
        addr_q <= cnt_q + 1'b1;
      end

      if (state == RD_DATA) begin
        rsp_rdata <= sram_din;
      end
    end
  end

  assign sram_addr = addr_q;

  sram_bus_drv #(
    .W (DATA_W)
  ) u_bus_drv (
    .drive_en (drive_q),
    .dout     (wdata_q),
    .din      (sram_din),
    .pad      (sram_data)
  );

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: a behavioural SRAM on the pins, a plain
// array holding the expected memory contents, and timing expectations taken
// directly from the cycle rules of the controller.
module tb_sram_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          init_start = 1'b0;
  logic [DW-1:0] init_data = '0;
  logic          init_busy;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          sram_cs;
  logic          sram_we;
  logic          sram_oe;
  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_data;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int conflicts = 0;

  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] sram_mem [DEPTH];

  sram_ctrl #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .init_start (init_start),
    .init_data  (init_data),
    .init_busy  (init_busy),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .sram_cs    (sram_cs),
    .sram_we    (sram_we),
    .sram_oe    (sram_oe),
    .sram_addr  (sram_addr),
    .sram_data  (sram_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM: asynchronous read while selected with oe, write at edge.
  assign sram_data = (sram_cs && sram_oe && !sram_we) ? sram_mem[sram_addr] : 'z;
  always @(posedge clk) begin
    if (sram_cs && sram_we) sram_mem[sram_addr] <= sram_data;
  end

  // Bus-contention monitor.
  always @(negedge clk) begin
    if (sram_we && sram_oe) conflicts <= conflicts + 1;
    else if (sram_oe && $isunknown(sram_data)) conflicts <= conflicts + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present a request and hold it until accepted; returns the acceptance cycle.
  // Called #1 after a posedge; returns #1 after the acceptance edge.
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int acc);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int acc;
    send(1'b1, a, d, acc);
    exp_mem[a] = d;
    @(negedge clk);
    check("wr_strobes", {29'd0, sram_cs, sram_we, sram_oe}, 32'b110);
    check("wr_addr", {28'd0, sram_addr}, {28'd0, a});
    check("wr_data", sram_data, d);
    @(negedge clk);
    check("wr_ready_again", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    int acc;
    int lat;
    send(1'b0, a, '0, acc);
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = cyc - acc;
        break;
      end
    end
    check("rd_latency", lat, 32'd3);
    check("rd_data", rsp_rdata, exp_mem[a]);
    @(negedge clk);
    check("rd_rsp_pulse", {31'd0, rsp_valid}, 32'd0);
    check("rd_ready_again", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Fill with optional write request raised in the same cycle as init_start.
  task automatic run_init(input logic [DW-1:0] fill, input logic with_req,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    int m;
    int busy_n;
    int acc;
    int ready_in_busy;
    m = cyc;
    busy_n = 0;
    acc = -1;
    ready_in_busy = 0;
    init_start = 1'b1;
    init_data  = fill;
    if (with_req) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = a;
      req_wdata = d;
    end
    @(negedge clk);
    check("init_ready_drop", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    init_start = 1'b0;
    init_data  = $urandom;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (init_busy) begin
        busy_n++;
        if (req_ready) ready_in_busy++;
      end else begin
        if (req_ready) acc = cyc;
        break;
      end
    end
    check("init_busy_cycles", busy_n, DEPTH);
    check("init_ready_while_busy", ready_in_busy, 32'd0);
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = fill;
    if (with_req) begin
      check("init_req_accept_cycle", acc - m, DEPTH + 1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      exp_mem[a] = d;
      @(posedge clk);
      #1;
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] held;
    logic [DW-1:0] fill;
    int found;

    // Reset held for two cycles.
    @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_init_busy", {31'd0, init_busy}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_strobes", {29'd0, sram_cs, sram_we, sram_oe}, 32'd0);
    check("rst_addr", {28'd0, sram_addr}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Single write then read.
    do_write(4'd5, 32'hDEADBEEF);
    do_read(4'd5);

    // rsp_rdata holds across a following write.
    held = rsp_rdata;
    do_write(4'd6, $urandom);
    check("rsp_rdata_hold", rsp_rdata, held);

    // Sweep: random data to every address, read back ascending then 15 -> 0.
    for (int i = 0; i < DEPTH; i++) do_write(AW'(i), $urandom);
    for (int i = 0; i < DEPTH; i++) do_read(AW'(i));
    for (int i = DEPTH - 1; i >= 0; i--) do_read(AW'(i));

    // Plain fill.
    run_init(32'hA5A5A5A5, 1'b0, '0, '0);
    do_read(4'd0);
    do_read(4'd15);
    do_read(4'd7);

    // Fill and write raised together: fill first, write afterwards survives.
    fill = $urandom;
    run_init(fill, 1'b1, 4'd9, 32'h0BADF00D);
    do_read(4'd9);
    do_read(4'd0);
    do_read(4'd15);

    // Known contents in the upper half, then reset in the middle of a fill.
    for (int i = 8; i < DEPTH; i++) do_write(AW'(i), $urandom);
    fill = 32'h12345678;
    init_start = 1'b1;
    init_data  = fill;
    @(posedge clk);
    #1;
    init_start = 1'b0;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (init_busy && sram_addr == 4'd7) begin
        found = 1;
        break;
      end
    end
    check("midinit_reached_addr7", found, 32'd1);
    rst_n = 1'b0;
    // The edge that applies reset still completes the write to address 7.
    for (int i = 0; i < 8; i++) exp_mem[i] = fill;
    @(negedge clk);
    check("midinit_busy_cleared", {31'd0, init_busy}, 32'd0);
    check("midinit_strobes_cleared", {29'd0, sram_cs, sram_we, sram_oe}, 32'd0);
    check("midinit_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midinit_ready", {31'd0, req_ready}, 32'd1);
    check("midinit_busy_stays_low", {31'd0, init_busy}, 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) do_read(AW'(i));

    check("bus_conflicts", conflicts, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
